// File: rtl/corr_bank_id.sv
// Early/prompt/late correlator bank for one GPS tracking channel: carrier and code
// wipe-off per tap, saturating integrate-and-dump, and a valid/ready dump register.

module corr_arm #(
    parameter int SAMPLE_W = 8,
    parameter int ACC_W    = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_load,
    input  logic                       i_clear,
    input  logic                       i_neg,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    output logic signed [ACC_W-1:0]    o_next,
    output logic                       o_sat
);
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]    A_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]    A_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic signed [ACC_W-1:0]    r_acc;
    logic signed [SAMPLE_W-1:0] w_term;
    logic signed [ACC_W-1:0]    w_term_x;
    logic signed [ACC_W:0]      w_sum;
    logic                       w_ovf;

    // Negating the most negative sample would wrap; pin it to the positive rail instead.
    always_comb begin
        w_term = i_sample;
        if (i_neg) w_term = (i_sample == S_MIN) ? S_MAX : -i_sample;
    end

    assign w_term_x = {{(ACC_W-SAMPLE_W){w_term[SAMPLE_W-1]}}, w_term};
    assign w_sum    = {r_acc[ACC_W-1], r_acc} + {w_term_x[ACC_W-1], w_term_x};
    assign w_ovf    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign o_next   = w_ovf ? (w_sum[ACC_W] ? A_MIN : A_MAX) : w_sum[ACC_W-1:0];
    assign o_sat    = i_en & ~i_load & w_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_load)       r_acc <= w_term_x;
            else if (i_clear) r_acc <= '0;
            else              r_acc <= o_next;
        end
    end
endmodule

module corr_bank_id #(
    parameter int SAMPLE_W    = 8,
    parameter int ACC_W       = 24,
    parameter int NUM_TAPS    = 3,
    parameter int TAP_SPACING = 2,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       carr_i_sign,
    input  logic                       carr_q_sign,
    input  logic                       prn_chip,
    input  logic                       epoch_start,
    input  logic [CNT_W-1:0]           int_len,
    input  logic                       dump_ready,
    output logic                       dump_valid,
    output logic [NUM_TAPS*ACC_W-1:0]  dump_i,
    output logic [NUM_TAPS*ACC_W-1:0]  dump_q,
    output logic                       overflow,
    output logic                       dropped
);
    localparam int L = TAP_SPACING*(NUM_TAPS-1)+1;

    logic [L-2:0]                    r_code;
    logic [L-1:0]                    w_chip;
    logic [CNT_W-1:0]                r_cnt;
    logic [CNT_W-1:0]                r_len;
    logic [CNT_W-1:0]                w_len_in;
    logic [CNT_W:0]                  w_cnt_inc;
    logic                            w_done;
    logic [NUM_TAPS-1:0][ACC_W-1:0]  w_next_i, w_next_q;
    logic [NUM_TAPS-1:0]             w_sat_i, w_sat_q;
    logic [NUM_TAPS-1:0][ACC_W-1:0]  r_dump_i, r_dump_q;
    logic                            r_dump_valid;
    logic                            r_overflow;
    logic                            r_dropped;

    // Tap 0 sees the live chip; bit j of w_chip is the chip delayed j samples.
    assign w_chip = {r_code, prn_chip};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_code <= '0;
        else if (sample_valid) r_code <= w_chip[L-2:0];
    end

    assign w_len_in  = (int_len == '0) ? CNT_W'(1) : int_len;
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    // ">=" rather than "==" so a period restarted at length 1 still closes.
    assign w_done    = sample_valid & ~epoch_start & (w_cnt_inc >= {1'b0, r_len});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_len <= CNT_W'(1);
        end else if (sample_valid) begin
            if (epoch_start) begin
                r_cnt <= CNT_W'(1);
                r_len <= w_len_in;
            end else if (w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic w_code;
        assign w_code = w_chip[k*TAP_SPACING];

        corr_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_i (
            .clk      (clk),
            .rst      (rst),
            .i_en     (sample_valid),
            .i_load   (epoch_start),
            .i_clear  (w_done),
            .i_neg    (w_code ^ carr_i_sign),
            .i_sample (sample_in),
            .o_next   (w_next_i[k]),
            .o_sat    (w_sat_i[k])
        );

        corr_arm #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_arm_q (
            .clk      (clk),
            .rst      (rst),
            .i_en     (sample_valid),
            .i_load   (epoch_start),
            .i_clear  (w_done),
            .i_neg    (w_code ^ carr_q_sign),
            .i_sample (sample_in),
            .o_next   (w_next_q[k]),
            .o_sat    (w_sat_q[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dump_i     <= '0;
            r_dump_q     <= '0;
            r_dump_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            if (|{w_sat_i, w_sat_q}) r_overflow <= 1'b1;
            if (w_done && (!r_dump_valid || dump_ready)) begin
                r_dump_i     <= w_next_i;
                r_dump_q     <= w_next_q;
                r_dump_valid <= 1'b1;
            end else if (w_done) begin
                r_dropped <= 1'b1;
            end else if (r_dump_valid && dump_ready) begin
                r_dump_valid <= 1'b0;
            end
        end
    end

    assign dump_valid = r_dump_valid;
    assign dump_i     = r_dump_i;
    assign dump_q     = r_dump_q;
    assign overflow   = r_overflow;
    assign dropped    = r_dropped;
endmodule

// File: tb/tb_corr_bank_id.sv
// Directed bench for corr_bank_id: a 24-bit-accumulator instance plus a 10-bit one
// sharing stimulus, so saturation can be exercised with small sample counts.

module tb_corr_bank_id;
    localparam int SW = 8, AW = 24, AW10 = 10, NT = 3, SP = 2, CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 sample_valid = 1'b0;
    logic [SW-1:0]        sample_in = '0;
    logic                 carr_i_sign = 1'b0, carr_q_sign = 1'b0, prn_chip = 1'b0;
    logic                 epoch_start = 1'b0, dump_ready = 1'b0;
    logic [CW-1:0]        int_len = '0;
    logic                 dump_valid, overflow, dropped;
    logic [NT*AW-1:0]     dump_i, dump_q;
    logic                 dv10, ov10, dr10;
    logic [NT*AW10-1:0]   di10, dq10;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    corr_bank_id #(.SAMPLE_W(SW), .ACC_W(AW), .NUM_TAPS(NT), .TAP_SPACING(SP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .carr_i_sign(carr_i_sign), .carr_q_sign(carr_q_sign), .prn_chip(prn_chip),
        .epoch_start(epoch_start), .int_len(int_len), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_i(dump_i), .dump_q(dump_q),
        .overflow(overflow), .dropped(dropped)
    );

    corr_bank_id #(.SAMPLE_W(SW), .ACC_W(AW10), .NUM_TAPS(NT), .TAP_SPACING(SP), .CNT_W(CW)) dut10 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
        .carr_i_sign(carr_i_sign), .carr_q_sign(carr_q_sign), .prn_chip(prn_chip),
        .epoch_start(epoch_start), .int_len(int_len), .dump_ready(dump_ready),
        .dump_valid(dv10), .dump_i(di10), .dump_q(dq10),
        .overflow(ov10), .dropped(dr10)
    );

    typedef struct {
        logic chip;
        logic cq;
        int   i0, i1, i2;
        int   q0, q1, q2;
    } vec_t;

    vec_t tv[8];

    function automatic logic [NT*AW-1:0] p24(input int a, input int b, input int c);
        logic [AW-1:0] x, y, z;
        x = a[AW-1:0];
        y = b[AW-1:0];
        z = c[AW-1:0];
        return {z, y, x};
    endfunction

    function automatic logic [NT*AW10-1:0] p10(input int a, input int b, input int c);
        logic [AW10-1:0] x, y, z;
        x = a[AW10-1:0];
        y = b[AW10-1:0];
        z = c[AW10-1:0];
        return {z, y, x};
    endfunction

    task automatic chk(input string name, input logic [NT*AW-1:0] act, input logic [NT*AW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle's inputs at a falling edge; return at the next falling edge.
    task automatic step(input logic v, input logic [SW-1:0] s, input logic ep, input logic [CW-1:0] len);
        sample_valid = v;
        sample_in    = s;
        epoch_start  = ep;
        int_len      = len;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        epoch_start  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, -3,  3,  3, -3,  3,  3};
        tv[1] = '{1'b0, 1'b0,  3,  3,  3,  3,  3,  3};
        tv[2] = '{1'b0, 1'b0,  3, -3,  3,  3, -3,  3};
        tv[3] = '{1'b0, 1'b0,  3,  3,  3,  3,  3,  3};
        tv[4] = '{1'b0, 1'b0,  3,  3, -3,  3,  3, -3};
        tv[5] = '{1'b0, 1'b0,  3,  3,  3,  3,  3,  3};
        tv[6] = '{1'b0, 1'b1,  3,  3,  3, -3, -3, -3};
        tv[7] = '{1'b1, 1'b1, -3,  3,  3,  3, -3, -3};

        #1 rst = 1'b1;
        #1;
        chk("reset dump_valid", 72'(dump_valid), 72'(0));
        chk("reset dump_i", dump_i, '0);
        chk("reset flags", 72'({overflow, dropped}), 72'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single-sample periods (length 1 from reset): chip pulse walks across taps.
        dump_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            prn_chip    = tv[r].chip;
            carr_q_sign = tv[r].cq;
            step(1'b1, 8'd3, 1'b0, '0);
            chk($sformatf("tbl%0d valid", r), 72'(dump_valid), 72'(1));
            chk($sformatf("tbl%0d dump_i", r), dump_i, p24(tv[r].i0, tv[r].i1, tv[r].i2));
            chk($sformatf("tbl%0d dump_q", r), dump_q, p24(tv[r].q0, tv[r].q1, tv[r].q2));
        end
        prn_chip = 1'b0;
        carr_q_sign = 1'b0;

        // Four-sample periods of +5.
        do_reset();
        step(1'b1, 8'd5, 1'b1, 16'd4);
        step(1'b1, 8'd5, 1'b0, '0);
        step(1'b1, 8'd5, 1'b0, '0);
        chk("len4 no early dump", 72'(dump_valid), 72'(0));
        step(1'b1, 8'd5, 1'b0, '0);
        chk("len4 valid", 72'(dump_valid), 72'(1));
        chk("len4 dump_i", dump_i, p24(20, 20, 20));
        chk("len4 dump_q", dump_q, p24(20, 20, 20));
        step(1'b1, 8'd5, 1'b0, '0);
        chk("len4 consumed", 72'(dump_valid), 72'(0));
        step(1'b1, 8'd5, 1'b0, '0);
        step(1'b1, 8'd5, 1'b0, '0);
        step(1'b1, 8'd5, 1'b0, '0);
        chk("len4 repeat", dump_i, p24(20, 20, 20));
        chk("len4 repeat valid", 72'(dump_valid), 72'(1));

        // Backpressure: second period's dump is dropped.
        do_reset();
        dump_ready = 1'b0;
        step(1'b1, 8'd5, 1'b1, 16'd4);
        for (int n = 0; n < 3; n++) step(1'b1, 8'd5, 1'b0, '0);
        chk("bp first valid", 72'(dump_valid), 72'(1));
        for (int n = 0; n < 3; n++) step(1'b1, 8'd10, 1'b0, '0);
        chk("bp no drop yet", 72'(dropped), 72'(0));
        step(1'b1, 8'd10, 1'b0, '0);
        chk("bp dropped", 72'(dropped), 72'(1));
        chk("bp held", dump_i, p24(20, 20, 20));
        chk("bp held valid", 72'(dump_valid), 72'(1));
        step(1'b0, 8'd0, 1'b0, '0);
        chk("bp drop pulse", 72'(dropped), 72'(0));
        dump_ready = 1'b1;
        step(1'b0, 8'd0, 1'b0, '0);
        chk("bp release", 72'(dump_valid), 72'(0));

        // Re-epoch mid-period with a new length.
        do_reset();
        step(1'b1, 8'd7, 1'b1, 16'd4);
        step(1'b1, 8'd7, 1'b0, '0);
        step(1'b1, 8'd5, 1'b1, 16'd3);
        chk("reepoch no dump", 72'(dump_valid), 72'(0));
        step(1'b1, 8'd5, 1'b0, '0);
        chk("reepoch no dump2", 72'(dump_valid), 72'(0));
        step(1'b1, 8'd5, 1'b0, '0);
        chk("reepoch valid", 72'(dump_valid), 72'(1));
        chk("reepoch dump_i", dump_i, p24(15, 15, 15));

        // Saturation in the 10-bit instance.
        do_reset();
        step(1'b1, 8'd127, 1'b1, 16'd8);
        for (int n = 0; n < 7; n++) step(1'b1, 8'd127, 1'b0, '0);
        chk("sat valid", 72'(dv10), 72'(1));
        chk("sat dump_i", 72'(di10), 72'(p10(511, 511, 511)));
        chk("sat dump_q", 72'(dq10), 72'(p10(511, 511, 511)));
        chk("sat overflow", 72'(ov10), 72'(1));
        chk("wide no overflow", 72'(overflow), 72'(0));
        chk("wide dump_i", dump_i, p24(1016, 1016, 1016));
        step(1'b1, 8'd1, 1'b1, 16'd8);
        for (int n = 0; n < 7; n++) step(1'b1, 8'd1, 1'b0, '0);
        chk("clean dump_i", 72'(di10), 72'(p10(8, 8, 8)));
        chk("overflow sticky", 72'(ov10), 72'(1));
        carr_i_sign = 1'b1;
        step(1'b1, 8'h80, 1'b1, 16'd2);
        step(1'b1, 8'h80, 1'b0, '0);
        chk("neg min dump_i", 72'(di10), 72'(p10(254, 254, 254)));
        chk("neg min dump_q", 72'(dq10), 72'(p10(-256, -256, -256)));
        chk("neg min wide", dump_i, p24(254, 254, 254));
        carr_i_sign = 1'b0;

        // Asynchronous reset mid-period with a held dump.
        do_reset();
        dump_ready = 1'b0;
        step(1'b1, 8'd5, 1'b1, 16'd2);
        step(1'b1, 8'd5, 1'b0, '0);
        chk("pre-rst valid", 72'(dump_valid), 72'(1));
        step(1'b1, 8'd5, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", 72'(dump_valid), 72'(0));
        chk("async rst dump_i", dump_i, '0);
        chk("async rst dump_q", dump_q, '0);
        chk("async rst ovf10", 72'(ov10), 72'(0));
        @(negedge clk);
        rst = 1'b0;
        dump_ready = 1'b1;
        step(1'b1, 8'd9, 1'b0, '0);
        chk("post-rst valid", 72'(dump_valid), 72'(1));
        chk("post-rst dump_i", dump_i, p24(9, 9, 9));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/corr_bank_id.md
Name: corr_bank_id

Overview:
- Parametrised early/prompt/late correlator bank for one GPS tracking channel.
- Per tap: wipes off the carrier (I and Q), wipes off the C/A code, then integrates and dumps over a programmable period.
- Tap count and tap spacing are configurable. Accumulators saturate. Dumps leave through a valid/ready register.
- Feeds the DLL discriminator (outer taps) and the Costas loop (prompt tap); replaces the fixed-width combinational xor_block mixers.

Parameters:
SAMPLE_W, 8, signed input sample width
ACC_W, 24, signed accumulator and dump width per tap per arm
NUM_TAPS, 3, number of correlator taps (odd, >=3); tap 0 earliest, tap NUM_TAPS/2 prompt, tap NUM_TAPS-1 latest
TAP_SPACING, 2, samples of code delay between adjacent taps (>=1)
CNT_W, 16, width of integration-length counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  qualifies sample_in, carrier signs and prn_chip
sample_in  in  SAMPLE_W  signed IF sample
carr_i_sign  in  1  carrier replica sign for I arm; 1 = -1
carr_q_sign  in  1  carrier replica sign for Q arm; 1 = -1
prn_chip  in  1  code replica chip at earliest-tap alignment; 1 = -1
epoch_start  in  1  with sample_valid: this sample starts a new integration period
int_len  in  CNT_W  samples per integration period; latched on epoch_start
dump_ready  in  1  downstream accepts dump
dump_valid  out  1  dump registers hold an unconsumed result
dump_i  out  NUM_TAPS*ACC_W  I accumulations; tap k at bits [k*ACC_W +: ACC_W]
dump_q  out  NUM_TAPS*ACC_W  Q accumulations; same packing
overflow  out  1  sticky: any accumulator saturated since reset
dropped  out  1  one-cycle pulse: a dump was lost to backpressure

Behaviour:
- Reset (async, any time, including mid-period or mid-handshake):
  - Clears the delay line, accumulators, sample counter, dump_i, dump_q, dump_valid, overflow and dropped.
  - Latched length becomes 1.
- Nothing advances while sample_valid=0.
- Code delay line:
  - Length L = TAP_SPACING*(NUM_TAPS-1)+1; shifts in prn_chip on each valid sample.
  - Tap k uses the chip delayed k*TAP_SPACING samples. Tap 0 is the current prn_chip, combinationally, not registered.
- Mixing, per tap k and arm a (I or Q):
  - sign = chip_k XOR carr_a_sign.
  - term = sample_in if sign=0, else -sample_in.
  - -(-2^(SAMPLE_W-1)) saturates to 2^(SAMPLE_W-1)-1.
- Accumulation:
  - acc += sign-extended term, in ACC_W+1 bits.
  - Clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp sets overflow (cleared only by reset).
- Sample counter counts valid samples in the current period.
  - On epoch_start & sample_valid: partial sums are discarded; accumulators load this sample's term; counter=1; int_len latched (0 is treated as 1).
  - Period completes on the valid sample where counter+1 = latched length. The sum including that sample is the dump; accumulators and counter are zeroed for the next sample.
  - epoch_start on a completing sample: epoch_start wins; no dump.
- Dump handshake:
  - Dump registers load on the cycle after the completing sample; dump_valid rises that same cycle (1-cycle latency).
  - dump_valid=1 & dump_ready=1 with no new dump: dump_valid falls next cycle.
  - New dump with dump_valid=0, or with dump_valid=1 & dump_ready=1 in the loading cycle: load; dump_valid stays 1.
  - New dump with dump_valid=1 & dump_ready=0: new result discarded, old held, dropped pulses 1 cycle.
  - dump_i and dump_q stay stable while dump_valid=1 & dump_ready=0.
- Throughput: one sample per clock sustained; int_len=1 yields a dump every valid sample.

Test Plan:
1. Config 3 taps, spacing 2, ACC_W=24. sample_in=+5, all signs 0, epoch_start on first sample, int_len=4, dump_ready=1 -> dump_valid one cycle after 4th sample; all six fields = +20; repeats every 4 samples.
2. int_len=1, sample=+3, carr signs 0, prn_chip=1 for one sample then 0 -> tap0 dumps -3 on that sample, tap1 -3 two samples later, tap2 -3 four samples later, else +3; carr_q_sign=1 negates Q only.
3. dump_ready=0 across two completed periods of values +20 and +40 -> dump holds +20, dropped pulses once; then dump_ready=1 -> valid clears next cycle.
4. ACC_W=10, sample=+127, int_len=8 -> dumps +511 (clamped), overflow=1 and stays 1 in later clean periods; sample=-128 with negating sign -> term +127.
5. epoch_start after 2 of 4 samples, int_len now 3 -> partial discarded; next dump = 3 samples' sum at the new boundary.
6. rst asserted asynchronously mid-period with dump_valid=1 -> all outputs 0 immediately; first dump after release covers only post-reset samples.
